seg_scan_mux: RTL



---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_decode.sv | 34 +++
 rtl/seg_scan_mux.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants (active-high, {g,f,e,d,c,b,a}) and scan helpers
// for display drivers.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One bit of a one-hot select: 1 when position pos is the selected index.
  function automatic logic onehot_sel(input logic [3:0] idx, input logic [3:0] pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-high 7-segment decoder; values 10..15 are
// blank unless hex_mode is set.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous
// input shadowing, per-digit blink and an anti-ghosting blank interval.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 12500,
  parameter int GHOST_CYC    = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0,
  parameter int WEI_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   wei,
  output logic [7:0]              duan
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]      GHOST_LD  = DIV_W'(GHOST_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]      FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] WEI_OFF   = (WEI_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            SEG_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || SCAN_DIV < 2 || GHOST_CYC < 0 ||
      GHOST_CYC >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_params
    $fatal(1, "seg_scan_mux: illegal parameter combination");
  end

  logic [DIV_W-1:0]        div_cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    started_reg;
  logic [DIV_W-1:0]        ghost_cnt_reg;
  logic [FRM_W-1:0]        frame_cnt_reg;
  logic                    blink_phase_reg;
  logic [4*NUM_DIGITS-1:0] digits_sh_reg;
  logic [NUM_DIGITS-1:0]   en_sh_reg;
  logic [NUM_DIGITS-1:0]   dp_sh_reg;
  logic [NUM_DIGITS-1:0]   blink_sh_reg;
  logic [NUM_DIGITS-1:0]   wei_reg;
  logic [7:0]              duan_reg;
  logic                    frame_start_reg;

  logic                    tick;
  logic                    frame_edge;
  logic [IDX_W-1:0]        next_idx;
  logic [IDX_W-1:0]        pat_idx;
  logic                    blink_phase_next;
  logic [4*NUM_DIGITS-1:0] sel_digits;
  logic [NUM_DIGITS-1:0]   sel_en;
  logic [NUM_DIGITS-1:0]   sel_dp;
  logic [NUM_DIGITS-1:0]   sel_blink;
  logic [3:0]              nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   onehot_next;
  logic [3:0]              pat_nibble;
  logic [6:0]              pat_seg;
  logic [7:0]              pattern_ah;
  logic [7:0]              duan_next;
  logic [NUM_DIGITS-1:0]   wei_next;

  assign tick       = (div_cnt_reg == DIV_LAST);
  assign next_idx   = (!started_reg || idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
  assign frame_edge = tick && (next_idx == '0);

  // At a frame boundary position 0 must already see the freshly sampled inputs.
  assign sel_digits = frame_edge ? digits   : digits_sh_reg;
  assign sel_en     = frame_edge ? digit_en : en_sh_reg;
  assign sel_dp     = frame_edge ? dp       : dp_sh_reg;
  assign sel_blink  = frame_edge ? blink    : blink_sh_reg;

  assign blink_phase_next = (frame_edge && frame_cnt_reg == FRM_LAST) ? ~blink_phase_reg
                                                                      : blink_phase_reg;

  // The tick path decodes the upcoming slot; the ghost-end path decodes the current one.
  assign pat_idx = tick ? next_idx : idx_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
    assign nib_arr[gi]     = sel_digits[4*gi +: 4];
    assign onehot_next[gi] = onehot_sel(4'(next_idx), 4'(gi));
  end

  assign pat_nibble = nib_arr[pat_idx];

  seg_decode u_seg_decode (
    .nibble   (pat_nibble),
    .hex_mode (HEX_MODE != 0),
    .seg      (pat_seg)
  );

  always_comb begin
    pattern_ah = {sel_dp[pat_idx], pat_seg};
    if (!sel_en[pat_idx] || (sel_blink[pat_idx] && blink_phase_next)) begin
      pattern_ah = 8'h00;
    end
    duan_next = (SEG_ACT_LOW != 0) ? ~pattern_ah : pattern_ah;
    wei_next  = sel_en[next_idx] ? onehot_next : '0;
    if (WEI_ACT_LOW != 0) begin
      wei_next = ~wei_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg     <= '0;
      idx_reg         <= '0;
      started_reg     <= 1'b0;
      ghost_cnt_reg   <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      digits_sh_reg   <= '0;
      en_sh_reg       <= '0;
      dp_sh_reg       <= '0;
      blink_sh_reg    <= '0;
      wei_reg         <= WEI_OFF;
      duan_reg        <= SEG_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_edge;
      if (tick) begin
        div_cnt_reg <= '0;
        idx_reg     <= next_idx;
        started_reg <= 1'b1;
        wei_reg     <= wei_next;
        if (GHOST_CYC > 0) begin
          duan_reg      <= SEG_OFF;
          ghost_cnt_reg <= GHOST_LD;
        end else begin
          duan_reg <= duan_next;
        end
        if (frame_edge) begin
          digits_sh_reg   <= digits;
          en_sh_reg       <= digit_en;
          dp_sh_reg       <= dp;
          blink_sh_reg    <= blink;
          frame_cnt_reg   <= (frame_cnt_reg == FRM_LAST) ? '0 : frame_cnt_reg + 1'b1;
          blink_phase_reg <= blink_phase_next;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
        if (ghost_cnt_reg != '0) begin
          ghost_cnt_reg <= ghost_cnt_reg - 1'b1;
          if (ghost_cnt_reg == DIV_W'(1)) begin
            duan_reg <= duan_next;
          end
        end
      end
    end
  end

  assign wei         = wei_reg;
  assign duan        = duan_reg;
  assign frame_start = frame_start_reg;

endmodule
